// File: rtl/nnz_pair_streamer.sv
// Packs CSC-ordered nonzeros into two lanes per cycle for conf_sys, fetching one x element per
// new column and replaying any lane-2 record that conf_sys rejects through the overlap response.
module nnz_pair_streamer #(
  parameter int VAL_W      = 32,
  parameter int ROW_W      = 12,
  parameter int BUF_DEPTH  = 4,
  parameter int FLUSH_WAIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             nz_valid,
  output logic             nz_ready,
  input  logic [VAL_W-1:0] nz_val,
  input  logic [ROW_W-1:0] nz_row,
  input  logic             nz_clast,
  input  logic             nz_mlast,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [VAL_W-1:0] x_data,
  input  logic             overlap,
  output logic [VAL_W-1:0] val1,
  output logic [ROW_W-1:0] rowIdx1,
  output logic             tag1,
  output logic [VAL_W-1:0] val2,
  output logic [ROW_W-1:0] rowIdx2,
  output logic             tag2,
  output logic [VAL_W-1:0] vec,
  output logic             busy,
  output logic             done
);

  // state  | meaning
  // IDLE   | no pass active, lanes empty
  // STREAM | accepting records and issuing lanes
  // DRAIN  | last record accepted; emptying the buffer and waiting out the final overlap
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam int AW   = $clog2(BUF_DEPTH);
  localparam int CW   = AW + 1;
  localparam int FW_W = $clog2(FLUSH_WAIT + 1);

  state_t state_q, state_d;

  logic [VAL_W-1:0] bval_q [BUF_DEPTH];
  logic [ROW_W-1:0] brow_q [BUF_DEPTH];
  logic             bcl_q  [BUF_DEPTH];
  logic             bml_q  [BUF_DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d, rd1;
  logic [CW-1:0]    cnt_q, cnt_d, pop_n;

  logic [VAL_W-1:0] val1_q, val1_d, val2_q, val2_d, vec_q, vec_d, xh_q, xh_d;
  logic [ROW_W-1:0] row1_q, row1_d, row2_q, row2_d;
  logic             tag1_q, tag1_d, tag2_q, tag2_d;
  logic             par_q, par_d, colopen_q, colopen_d, xh_v_q, xh_v_d, done_q, done_d;
  logic [FW_W-1:0]  flush_q, flush_d;

  logic             run, rp_hit, push, have1, have2, n0, n1;
  logic             x1_port, x1_ok, x2_ok, lone_go, pair, single, issue1, prefetch;
  logic [VAL_W-1:0] xa, xb;

  assign run      = (state_q != IDLE);
  assign rd1      = rd_q + AW'(1);
  assign nz_ready = (state_q == STREAM) && (cnt_q != CW'(BUF_DEPTH));
  assign push     = nz_valid && nz_ready;
  assign have1    = (cnt_q != '0);
  assign have2    = (cnt_q >= CW'(2));

  // A rejected lane 2 takes priority over everything and goes straight back out in lane 1.
  assign rp_hit   = run && overlap && (val2_q != '0);

  // n0: head record opens a new column; n1: the record behind it does.
  assign n0       = colopen_q;
  assign n1       = bcl_q[rd_q];
  assign x1_port  = n0 && !xh_v_q;
  assign x1_ok    = !n0 || xh_v_q || x_valid;
  assign x2_ok    = !n1 || (x_valid && !x1_port);
  assign lone_go  = bml_q[rd_q] || (flush_q == FW_W'(FLUSH_WAIT));
  assign pair     = run && !rp_hit && have2 && x1_ok && x2_ok;
  assign single   = run && !rp_hit && !pair && have1 && x1_ok && (have2 || lone_go);
  assign issue1   = pair || single;

  // While the head waits for a partner, its column x is fetched early so a later
  // column-spanning pair can take the second x from the port in the same cycle.
  assign prefetch = run && !rp_hit && !issue1 && have1 && x1_port;
  assign x_ready  = (issue1 && x1_port) || (pair && n1) || prefetch;

  assign xa       = n0 ? (xh_v_q ? xh_q : x_data) : vec_q;
  assign xb       = n1 ? x_data : xa;
  assign pop_n    = pair ? CW'(2) : (single ? CW'(1) : '0);

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q + pop_n[AW-1:0];
    wr_d      = wr_q + AW'(push);
    cnt_d     = cnt_q + CW'(push) - pop_n;
    val1_d    = '0;
    row1_d    = '0;
    tag1_d    = 1'b0;
    val2_d    = '0;
    row2_d    = '0;
    tag2_d    = 1'b0;
    vec_d     = vec_q;
    xh_d      = xh_q;
    xh_v_d    = xh_v_q;
    par_d     = par_q;
    colopen_d = colopen_q;
    flush_d   = flush_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = STREAM;
          par_d     = 1'b0;
          colopen_d = 1'b1;
          xh_v_d    = 1'b0;
          flush_d   = '0;
        end
      end
      STREAM: if (push && nz_mlast) state_d = DRAIN;
      DRAIN: begin
        if (!have1 && !rp_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (run) begin
      if (rp_hit) begin
        val1_d = val2_q;
        row1_d = row2_q;
        tag1_d = tag2_q;
      end else if (issue1) begin
        val1_d    = bval_q[rd_q];
        row1_d    = brow_q[rd_q];
        tag1_d    = par_q;
        vec_d     = pair ? xb : xa;
        colopen_d = pair ? bcl_q[rd1] : bcl_q[rd_q];
        par_d     = par_q ^ bcl_q[rd_q] ^ (pair && bcl_q[rd1]);
        if (n0 && xh_v_q) xh_v_d = 1'b0;
        if (pair) begin
          val2_d = bval_q[rd1];
          row2_d = brow_q[rd1];
          tag2_d = par_q ^ bcl_q[rd_q];
        end
      end
      if (prefetch && x_valid) begin
        xh_v_d = 1'b1;
        xh_d   = x_data;
      end
      if (issue1 || cnt_q != CW'(1)) flush_d = '0;
      else if (!rp_hit && flush_q != FW_W'(FLUSH_WAIT)) flush_d = flush_q + FW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      val1_q    <= '0;
      row1_q    <= '0;
      tag1_q    <= 1'b0;
      val2_q    <= '0;
      row2_q    <= '0;
      tag2_q    <= 1'b0;
      vec_q     <= '0;
      xh_q      <= '0;
      xh_v_q    <= 1'b0;
      par_q     <= 1'b0;
      colopen_q <= 1'b0;
      flush_q   <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        bval_q[i] <= '0;
        brow_q[i] <= '0;
        bcl_q[i]  <= 1'b0;
        bml_q[i]  <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      val1_q    <= val1_d;
      row1_q    <= row1_d;
      tag1_q    <= tag1_d;
      val2_q    <= val2_d;
      row2_q    <= row2_d;
      tag2_q    <= tag2_d;
      vec_q     <= vec_d;
      xh_q      <= xh_d;
      xh_v_q    <= xh_v_d;
      par_q     <= par_d;
      colopen_q <= colopen_d;
      flush_q   <= flush_d;
      done_q    <= done_d;
      if (push) begin
        bval_q[wr_q] <= nz_val;
        brow_q[wr_q] <= nz_row;
        bcl_q[wr_q]  <= nz_clast;
        bml_q[wr_q]  <= nz_mlast;
      end
    end
  end

  assign val1    = val1_q;
  assign rowIdx1 = row1_q;
  assign tag1    = tag1_q;
  assign val2    = val2_q;
  assign rowIdx2 = row2_q;
  assign tag2    = tag2_q;
  assign vec     = vec_q;
  assign busy    = run;
  assign done    = done_q;

endmodule
